// File: rtl/cal_pkg.sv
// Shared types and constants for the calendar sequencer: FSM states, weekday
// encoding, reset date and small BCD helpers.
package cal_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADVANCE,
    VALIDATE,
    DOW
  } cal_state_e;

  localparam logic [2:0] DOW_SAT = 3'd0;
  localparam logic [2:0] DOW_SUN = 3'd1;
  localparam logic [2:0] DOW_MON = 3'd2;
  localparam logic [2:0] DOW_TUE = 3'd3;
  localparam logic [2:0] DOW_WED = 3'd4;
  localparam logic [2:0] DOW_THU = 3'd5;
  localparam logic [2:0] DOW_FRI = 3'd6;

  localparam logic [7:0] RST_DAY   = 8'h01;
  localparam logic [7:0] RST_MONTH = 8'h01;
  localparam logic [7:0] RST_YEAR  = 8'h00;
  localparam logic [2:0] RST_DOW   = DOW_SAT;

  function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  // Two-digit BCD increment; 99 rolls over to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] b);
    if (b == 8'h99)
      return 8'h00;
    else if (b[3:0] == 4'h9)
      return {b[7:4] + 4'h1, 4'h0};
    else
      return {b[7:4], b[3:0] + 4'h1};
  endfunction

  // Year mod 4 == 0 on the BCD digits; bit 4 is the LSB of the tens digit.
  function automatic logic leap_year(input logic [7:0] yr);
    if (yr[4])
      return (yr[3:0] == 4'h2) || (yr[3:0] == 4'h6);
    else
      return (yr[3:0] == 4'h0) || (yr[3:0] == 4'h4) || (yr[3:0] == 4'h8);
  endfunction

endpackage

// File: rtl/zellers_congruence.sv
// Combinational Zeller weekday for a 20xx BCD date (0=Sat .. 6=Fri).
module zellers_congruence
  import cal_pkg::*;
(
  input  logic [7:0] day_i,
  input  logic [7:0] month_i,
  input  logic [7:0] year_i,
  output logic [2:0] dow_o
);

  logic [9:0] q, m, yy, m_adj, k, j, sum;

  always_comb begin
    q  = 10'(bcd_to_bin(day_i));
    m  = 10'(bcd_to_bin(month_i));
    yy = 10'(bcd_to_bin(year_i));
    // Jan/Feb count as months 13/14 of the previous year; 2000 borrows from 1999.
    if (m < 10'd3) begin
      m_adj = m + 10'd12;
      if (yy == 10'd0) begin
        k = 10'd99;
        j = 10'd19;
      end else begin
        k = yy - 10'd1;
        j = 10'd20;
      end
    end else begin
      m_adj = m;
      k     = yy;
      j     = 10'd20;
    end
    sum = q + (10'd13 * (m_adj + 10'd1)) / 10'd5 + k + k / 10'd4
        + j / 10'd4 + 10'd5 * j;
    dow_o = 3'(sum % 10'd7);
  end

endmodule

// File: rtl/calendar_sequencer.sv
// BCD calendar date sequencer with set/validate path and registered weekday.
// Leap-year February is enabled by defining CAL_LEAP_YEAR_EN.
module calendar_sequencer
  import cal_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       day_tick,
  input  logic       set_req,
  input  logic [7:0] set_day,
  input  logic [7:0] set_month,
  input  logic [7:0] set_year,
  output logic       set_ack,
  output logic       set_err,
  output logic [7:0] day,
  output logic [7:0] month,
  output logic [7:0] year,
  output logic [2:0] day_of_week,
  output logic       dow_valid,
  output logic       busy,
  output logic       tick_overrun
);

  cal_state_e state_q, state_d;
  logic [7:0] day_q, day_d, month_q, month_d, year_q, year_d;
  logic [7:0] set_day_q, set_day_d, set_month_q, set_month_d, set_year_q, set_year_d;
  logic [2:0] dow_q, dow_d, zeller_dow;
  logic       dow_valid_q, dow_valid_d, set_ack_q, set_ack_d, set_err_q, set_err_d;
  logic       pending_q, pending_d, overrun_q, overrun_d;
  logic       set_go, set_ok, set_digits_ok, cur_leap, set_leap;

  function automatic logic [7:0] month_len(input logic [7:0] mon, input logic leap);
    case (mon)
      8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: month_len = 8'h31;
      8'h04, 8'h06, 8'h09, 8'h11:                      month_len = 8'h30;
      8'h02:   month_len = leap ? 8'h29 : 8'h28;
      default: month_len = 8'h00;
    endcase
  endfunction

`ifdef CAL_LEAP_YEAR_EN
  assign cur_leap = leap_year(year_q);
  assign set_leap = leap_year(set_year_q);
`else
  assign cur_leap = 1'b0;
  assign set_leap = 1'b0;
`endif

  zellers_congruence u_zeller (
    .day_i   (day_q),
    .month_i (month_q),
    .year_i  (year_q),
    .dow_o   (zeller_dow)
  );

  assign set_go = set_req && !set_ack_q && !set_err_q;

  // BCD compares are monotonic once every digit is known to be <= 9.
  assign set_digits_ok = (set_day_q[7:4]   <= 4'd9) && (set_day_q[3:0]   <= 4'd9) &&
                         (set_month_q[7:4] <= 4'd9) && (set_month_q[3:0] <= 4'd9) &&
                         (set_year_q[7:4]  <= 4'd9) && (set_year_q[3:0]  <= 4'd9);
  assign set_ok = set_digits_ok &&
                  (set_month_q >= 8'h01) && (set_month_q <= 8'h12) &&
                  (set_day_q >= 8'h01) && (set_day_q <= month_len(set_month_q, set_leap));

  always_comb begin
    state_d     = state_q;
    day_d       = day_q;
    month_d     = month_q;
    year_d      = year_q;
    set_day_d   = set_day_q;
    set_month_d = set_month_q;
    set_year_d  = set_year_q;
    dow_d       = dow_q;
    dow_valid_d = dow_valid_q;
    set_ack_d   = 1'b0;
    set_err_d   = 1'b0;
    pending_d   = pending_q;
    overrun_d   = overrun_q;

    if (day_tick) begin
      if (pending_q)
        overrun_d = 1'b1;
      else if ((state_q != IDLE) || set_go)
        pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (set_go) begin
          state_d     = VALIDATE;
          set_day_d   = set_day;
          set_month_d = set_month;
          set_year_d  = set_year;
        end else if (day_tick || pending_q) begin
          state_d     = ADVANCE;
          dow_valid_d = 1'b0;
          if (pending_q)
            pending_d = 1'b0;
        end
      end
      ADVANCE: begin
        state_d = DOW;
        if (day_q < month_len(month_q, cur_leap)) begin
          day_d = bcd_inc(day_q);
        end else begin
          day_d = 8'h01;
          if (month_q == 8'h12) begin
            month_d = 8'h01;
            year_d  = bcd_inc(year_q);
          end else begin
            month_d = bcd_inc(month_q);
          end
        end
      end
      VALIDATE: begin
        if (set_ok) begin
          state_d     = DOW;
          day_d       = set_day_q;
          month_d     = set_month_q;
          year_d      = set_year_q;
          set_ack_d   = 1'b1;
          dow_valid_d = 1'b0;
        end else begin
          state_d   = IDLE;
          set_err_d = 1'b1;
        end
      end
      DOW: begin
        state_d     = IDLE;
        dow_d       = zeller_dow;
        dow_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      day_q       <= RST_DAY;
      month_q     <= RST_MONTH;
      year_q      <= RST_YEAR;
      set_day_q   <= '0;
      set_month_q <= '0;
      set_year_q  <= '0;
      dow_q       <= RST_DOW;
      dow_valid_q <= 1'b1;
      set_ack_q   <= 1'b0;
      set_err_q   <= 1'b0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      day_q       <= day_d;
      month_q     <= month_d;
      year_q      <= year_d;
      set_day_q   <= set_day_d;
      set_month_q <= set_month_d;
      set_year_q  <= set_year_d;
      dow_q       <= dow_d;
      dow_valid_q <= dow_valid_d;
      set_ack_q   <= set_ack_d;
      set_err_q   <= set_err_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
    end
  end

  assign set_ack      = set_ack_q;
  assign set_err      = set_err_q;
  assign day          = day_q;
  assign month        = month_q;
  assign year         = year_q;
  assign day_of_week  = dow_q;
  assign dow_valid    = dow_valid_q;
  assign busy         = (state_q != IDLE);
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_calendar_sequencer.sv
// Self-checking bench for calendar_sequencer: vector table with scoreboard,
// plus latency, collision, overrun and mid-operation reset sequences.
module tb_calendar_sequencer;

  logic       clk = 1'b0;
  logic       rst, day_tick, set_req;
  logic [7:0] set_day, set_month, set_year;
  logic       set_ack, set_err, dow_valid, busy, tick_overrun;
  logic [7:0] day, month, year;
  logic [2:0] day_of_week;

  int unsigned total  = 0;
  int unsigned passed = 0;

  typedef struct {
    bit         is_set;
    logic [7:0] sd, sm, sy;
    logic [7:0] ed, em, ey;
    logic [2:0] edow;
    bit         eerr;
  } vec_t;

  typedef struct {
    logic [7:0] d, m, y;
    logic [2:0] dow;
    bit         ack, err;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  calendar_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .day_tick     (day_tick),
    .set_req      (set_req),
    .set_day      (set_day),
    .set_month    (set_month),
    .set_year     (set_year),
    .set_ack      (set_ack),
    .set_err      (set_err),
    .day          (day),
    .month        (month),
    .year         (year),
    .day_of_week  (day_of_week),
    .dow_valid    (dow_valid),
    .busy         (busy),
    .tick_overrun (tick_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, need %0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    total++;
    $display("FAIL %s: timed out waiting for the DUT, busy=%0b", name, busy);
  endtask

  function automatic vec_t mk(bit s, logic [7:0] sd, sm, sy, ed, em, ey,
                              logic [2:0] dw, bit e);
    vec_t v;
    v.is_set = s; v.sd = sd; v.sm = sm; v.sy = sy;
    v.ed = ed; v.em = em; v.ey = ey; v.edow = dw; v.eerr = e;
    return v;
  endfunction

  task automatic check_result(input string tag, input bit saw_ack, input bit saw_err);
    exp_t e;
    e = sbq.pop_front();
    chk({tag, " day"},   day,         e.d);
    chk({tag, " month"}, month,       e.m);
    chk({tag, " year"},  year,        e.y);
    chk({tag, " dow"},   day_of_week, e.dow);
    chk({tag, " valid"}, dow_valid,   1);
    chk({tag, " ack"},   saw_ack,     e.ack);
    chk({tag, " err"},   saw_err,     e.err);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    bit   saw_ack = 0, saw_err = 0, done = 0;
    e.d = v.ed; e.m = v.em; e.y = v.ey; e.dow = v.edow;
    e.ack = v.is_set && !v.eerr; e.err = v.eerr;
    sbq.push_back(e);
    if (v.is_set) begin
      set_req = 1'b1; set_day = v.sd; set_month = v.sm; set_year = v.sy;
    end else begin
      day_tick = 1'b1;
    end
    @(negedge clk);
    set_req = 1'b0; day_tick = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (set_ack) saw_ack = 1;
      if (set_err) saw_err = 1;
      if (!busy) begin done = 1; break; end
      @(negedge clk);
    end
    if (!done) timeout_fail($sformatf("vec%0d", idx));
    check_result($sformatf("vec%0d", idx), saw_ack, saw_err);
    chk($sformatf("vec%0d overrun", idx), tick_overrun, 0);
    @(negedge clk);
  endtask

  initial begin
    bit   saw_ack, done;
    exp_t e;

    rst = 1'b1; day_tick = 1'b0; set_req = 1'b0;
    set_day = '0; set_month = '0; set_year = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst day",     day,          8'h01);
    chk("rst month",   month,        8'h01);
    chk("rst year",    year,         8'h00);
    chk("rst dow",     day_of_week,  0);
    chk("rst valid",   dow_valid,    1);
    chk("rst busy",    busy,         0);
    chk("rst ack",     set_ack,      0);
    chk("rst err",     set_err,      0);
    chk("rst overrun", tick_overrun, 0);

    // Set latency: date at n+1, weekday at n+2 (2024-05-01 is Wednesday).
    set_req = 1'b1; set_day = 8'h01; set_month = 8'h05; set_year = 8'h24;
    @(negedge clk);
    set_req = 1'b0;
    chk("lat set n busy",   busy,  1);
    chk("lat set n month",  month, 8'h01);
    @(negedge clk);
    chk("lat set n1 month", month, 8'h05);
    chk("lat set n1 year",  year,  8'h24);
    chk("lat set n1 ack",   set_ack, 1);
    chk("lat set n1 valid", dow_valid, 0);
    @(negedge clk);
    chk("lat set n2 dow",   day_of_week, 4);
    chk("lat set n2 valid", dow_valid, 1);
    chk("lat set n2 ack",   set_ack, 0);
    chk("lat set n2 busy",  busy, 0);

    // Tick latency: 2024-05-02 is Thursday.
    day_tick = 1'b1;
    @(negedge clk);
    day_tick = 1'b0;
    chk("lat tick n valid", dow_valid, 0);
    chk("lat tick n day",   day, 8'h01);
    @(negedge clk);
    chk("lat tick n1 day",  day, 8'h02);
    @(negedge clk);
    chk("lat tick n2 dow",  day_of_week, 5);
    chk("lat tick n2 valid", dow_valid, 1);
    @(negedge clk);

    vecs.push_back(mk(1, 8'h28, 8'h02, 8'h24, 8'h28, 8'h02, 8'h24, 4, 0));
`ifdef CAL_LEAP_YEAR_EN
    vecs.push_back(mk(0, 0, 0, 0, 8'h29, 8'h02, 8'h24, 5, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h01, 8'h03, 8'h24, 6, 0));
`else
    vecs.push_back(mk(0, 0, 0, 0, 8'h01, 8'h03, 8'h24, 6, 0));
    vecs.push_back(mk(1, 8'h29, 8'h02, 8'h24, 8'h01, 8'h03, 8'h24, 6, 1));
`endif
    vecs.push_back(mk(1, 8'h29, 8'h02, 8'h23, 8'h01, 8'h03, 8'h24, 6, 1));
    vecs.push_back(mk(1, 8'h31, 8'h12, 8'h99, 8'h31, 8'h12, 8'h99, 5, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h01, 8'h01, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h31, 8'h04, 8'h24, 8'h01, 8'h01, 8'h00, 0, 1));
    vecs.push_back(mk(1, 8'h1A, 8'h05, 8'h24, 8'h01, 8'h01, 8'h00, 0, 1));
    vecs.push_back(mk(1, 8'h00, 8'h05, 8'h24, 8'h01, 8'h01, 8'h00, 0, 1));
    vecs.push_back(mk(1, 8'h15, 8'h13, 8'h24, 8'h01, 8'h01, 8'h00, 0, 1));
    vecs.push_back(mk(1, 8'h30, 8'h06, 8'h24, 8'h30, 8'h06, 8'h24, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h01, 8'h07, 8'h24, 2, 0));
    vecs.push_back(mk(1, 8'h09, 8'h09, 8'h19, 8'h09, 8'h09, 8'h19, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h10, 8'h09, 8'h19, 3, 0));
    vecs.push_back(mk(1, 8'h30, 8'h09, 8'h19, 8'h30, 8'h09, 8'h19, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h01, 8'h10, 8'h19, 3, 0));
    vecs.push_back(mk(1, 8'h31, 8'h01, 8'h00, 8'h31, 8'h01, 8'h00, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h01, 8'h02, 8'h00, 3, 0));
    vecs.push_back(mk(1, 8'h28, 8'h02, 8'h00, 8'h28, 8'h02, 8'h00, 2, 0));
`ifdef CAL_LEAP_YEAR_EN
    vecs.push_back(mk(0, 0, 0, 0, 8'h29, 8'h02, 8'h00, 3, 0));
`else
    vecs.push_back(mk(0, 0, 0, 0, 8'h01, 8'h03, 8'h00, 4, 0));
`endif
    vecs.push_back(mk(1, 8'h28, 8'h02, 8'h12, 8'h28, 8'h02, 8'h12, 3, 0));
`ifdef CAL_LEAP_YEAR_EN
    vecs.push_back(mk(0, 0, 0, 0, 8'h29, 8'h02, 8'h12, 4, 0));
`else
    vecs.push_back(mk(0, 0, 0, 0, 8'h01, 8'h03, 8'h12, 5, 0));
`endif

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Collision: set and tick together; the pending tick runs after the set.
    e.d = 8'h02; e.m = 8'h05; e.y = 8'h24; e.dow = 5; e.ack = 1; e.err = 0;
    sbq.push_back(e);
    set_req = 1'b1; day_tick = 1'b1;
    set_day = 8'h01; set_month = 8'h05; set_year = 8'h24;
    @(negedge clk);
    set_req = 1'b0; day_tick = 1'b0;
    saw_ack = 0; done = 0;
    for (int i = 0; i < 30; i++) begin
      if (set_ack) saw_ack = 1;
      if (!busy && dow_valid && day == 8'h02) begin done = 1; break; end
      @(negedge clk);
    end
    if (!done) timeout_fail("collision");
    check_result("collision", saw_ack, 0);
    chk("collision overrun", tick_overrun, 0);
    @(negedge clk);

    // Overrun: three back-to-back ticks give two advances and a sticky flag.
    e.d = 8'h04; e.m = 8'h05; e.y = 8'h24; e.dow = 0; e.ack = 0; e.err = 0;
    sbq.push_back(e);
    day_tick = 1'b1;
    repeat (3) @(negedge clk);
    day_tick = 1'b0;
    done = 0;
    for (int i = 0; i < 30; i++) begin
      if (!busy && dow_valid && day == 8'h04) begin done = 1; break; end
      @(negedge clk);
    end
    if (!done) timeout_fail("overrun");
    check_result("overrun", 0, 0);
    chk("overrun flag", tick_overrun, 1);
    repeat (4) @(negedge clk);
    chk("overrun settle day",  day,  8'h04);
    chk("overrun settle busy", busy, 0);
    chk("overrun sticky",      tick_overrun, 1);

    // Reset while a tick is in flight and another is pending.
    day_tick = 1'b1;
    repeat (2) @(negedge clk);
    day_tick = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst busy",    busy, 0);
    chk("midrst day",     day, 8'h01);
    chk("midrst month",   month, 8'h01);
    chk("midrst year",    year, 8'h00);
    chk("midrst dow",     day_of_week, 0);
    chk("midrst valid",   dow_valid, 1);
    chk("midrst overrun", tick_overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst no pending day",  day, 8'h01);
    chk("midrst no pending busy", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
